// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game controller and datapath: state codes,
// mode LED patterns and the strobe bundle the controller drives.
package simon_pkg;

  typedef enum logic [1:0] {
    S_INPUT    = 2'b00,
    S_PLAYBACK = 2'b01,
    S_DONE     = 2'b10,
    S_REPEAT   = 2'b11
  } state_e;

  localparam logic [2:0] LED_MODE_INPUT    = 3'b001;
  localparam logic [2:0] LED_MODE_PLAYBACK = 3'b010;
  localparam logic [2:0] LED_MODE_REPEAT   = 3'b100;
  localparam logic [2:0] LED_MODE_DONE     = 3'b111;

  typedef struct packed {
    logic scld;
    logic srld;
    logic rcld;
    logic rcclr;
    logic led_sel;
  } strobes_t;

  function automatic logic [2:0] mode_leds_of(input state_e s);
    logic [2:0] leds;
    case (s)
      S_INPUT:    leds = LED_MODE_INPUT;
      S_PLAYBACK: leds = LED_MODE_PLAYBACK;
      S_REPEAT:   leds = LED_MODE_REPEAT;
      S_DONE:     leds = LED_MODE_DONE;
      default:    leds = LED_MODE_INPUT;
    endcase
    return leds;
  endfunction

endpackage

// File: rtl/simon_controller_if.sv
// Controller <-> datapath signal bundle. All signals are level strobes sampled
// on the shared posedge; there is no valid/ready handshake on this link.
interface simon_controller_if #(
  parameter int SCORE_W = 7
);
  logic               is_legal;
  logic               correct_pattern;
  logic               is_last_element;
  logic               dp_reset;
  logic               scld;
  logic               srld;
  logic               rcld;
  logic               rcclr;
  logic               led_sel;
  logic [2:0]         mode_leds;
  logic [SCORE_W-1:0] score;
  logic               win;

  modport master (
    input  is_legal, correct_pattern, is_last_element,
    output dp_reset, scld, srld, rcld, rcclr, led_sel, mode_leds, score, win
  );

  modport slave (
    output is_legal, correct_pattern, is_last_element,
    input  dp_reset, scld, srld, rcld, rcclr, led_sel, mode_leds, score, win
  );
endinterface

// File: rtl/simon_controller.sv
// Sequences the Simon datapath through INPUT -> PLAYBACK -> REPEAT -> ... -> DONE
// and keeps a saturating round score plus the win flag.
module simon_controller
  import simon_pkg::*;
#(
  parameter int MAX_LEN = 64,
  parameter int SCORE_W = 7
) (
  input  logic                clk,
  input  logic                reset,
  simon_controller_if.master  bus,
  output state_e              state_o
);

  localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(MAX_LEN);

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               win_q, win_d;
  logic [SCORE_W-1:0] score_inc;
  strobes_t           st;

  assign score_inc = (score_q == SCORE_MAX) ? score_q : score_q + 1'b1;

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    win_d   = win_q;
    st      = '0;
    case (state_q)
      S_INPUT: begin
        st.led_sel = 1'b1;
        if (bus.is_legal) begin
          st.srld  = 1'b1;
          st.scld  = 1'b1;
          st.rcclr = 1'b1;
          state_d  = S_PLAYBACK;
        end
      end
      S_PLAYBACK: begin
        if (bus.is_last_element) begin
          st.rcclr = 1'b1;
          state_d  = S_REPEAT;
        end else begin
          st.rcld = 1'b1;
        end
      end
      S_REPEAT: begin
        st.led_sel = 1'b1;
        // A wrong entry ends the game even on the last element.
        if (!bus.correct_pattern) begin
          st.rcclr = 1'b1;
          win_d    = 1'b0;
          state_d  = S_DONE;
        end else if (bus.is_last_element) begin
          score_d = score_inc;
          if (score_inc == SCORE_MAX) begin
            st.rcclr = 1'b1;
            win_d    = 1'b1;
            state_d  = S_DONE;
          end else begin
            state_d = S_INPUT;
          end
        end else begin
          st.rcld = 1'b1;
        end
      end
      S_DONE: begin
        if (bus.is_last_element) st.rcclr = 1'b1;
        else                     st.rcld  = 1'b1;
      end
      default: state_d = S_INPUT;
    endcase
    // Reset overrides every strobe so nothing reaches the datapath that edge.
    if (!reset) begin
      st         = '0;
      st.led_sel = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_INPUT;
      score_q <= '0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      win_q   <= win_d;
    end
  end

  assign bus.dp_reset  = ~reset;
  assign bus.scld      = st.scld;
  assign bus.srld      = st.srld;
  assign bus.rcld      = st.rcld;
  assign bus.rcclr     = st.rcclr;
  assign bus.led_sel   = st.led_sel;
  assign bus.mode_leds = reset ? mode_leds_of(state_q) : LED_MODE_INPUT;
  assign bus.score     = score_q;
  assign bus.win       = win_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_simon_controller.sv
// Step-by-step bench for simon_controller with MAX_LEN=2: each step drives the
// status inputs, queues the expected output vector and compares it before the edge.
module tb_simon_controller;
  import simon_pkg::*;

  localparam int MAX_LEN = 2;
  localparam int SCORE_W = 2;
  localparam int VW      = 12;

  logic   clk;
  logic   reset;
  state_e state_o;

  int tests_run;
  int tests_failed;

  logic [VW-1:0] exp_q[$];

  simon_controller_if #(.SCORE_W(SCORE_W)) bus ();

  simon_controller #(.MAX_LEN(MAX_LEN), .SCORE_W(SCORE_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.master),
    .state_o (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {dp_reset, scld, srld, rcld, rcclr, led_sel, mode_leds, score, win}
  function automatic logic [VW-1:0] ev(input logic dpr, input logic scld, input logic srld,
                                       input logic rcld, input logic rcclr, input logic led,
                                       input logic [2:0] mode, input logic [1:0] sc,
                                       input logic w);
    return {dpr, scld, srld, rcld, rcclr, led, mode, sc, w};
  endfunction

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic legal,
                      input logic corr, input logic last, input logic [VW-1:0] exp);
    logic [VW-1:0] obs;
    logic [VW-1:0] want;
    @(negedge clk);
    reset               = rst;
    bus.is_legal        = legal;
    bus.correct_pattern = corr;
    bus.is_last_element = last;
    exp_q.push_back(exp);
    #1;
    obs = {bus.dp_reset, bus.scld, bus.srld, bus.rcld, bus.rcclr, bus.led_sel,
           bus.mode_leds, bus.score, bus.win};
    want = exp_q.pop_front();
    check(tag, obs, want);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset               = 1'b0;
    bus.is_legal        = 1'b0;
    bus.correct_pattern = 1'b0;
    bus.is_last_element = 1'b0;
    repeat (2) @(posedge clk);

    // reset forces strobes low even with a legal entry present
    step("reset",       0, 1, 0, 0, ev(1, 0, 0, 0, 0, 1, 3'b001, 2'd0, 0));
    step("in_idle0",    1, 0, 0, 0, ev(0, 0, 0, 0, 0, 1, 3'b001, 2'd0, 0));
    step("in_idle1",    1, 0, 1, 1, ev(0, 0, 0, 0, 0, 1, 3'b001, 2'd0, 0));
    step("in_idle2",    1, 0, 0, 1, ev(0, 0, 0, 0, 0, 1, 3'b001, 2'd0, 0));
    step("in_legal",    1, 1, 0, 0, ev(0, 1, 1, 0, 1, 1, 3'b001, 2'd0, 0));
    step("pb_next",     1, 0, 0, 0, ev(0, 0, 0, 1, 0, 0, 3'b010, 2'd0, 0));
    step("pb_last",     1, 0, 0, 1, ev(0, 0, 0, 0, 1, 0, 3'b010, 2'd0, 0));
    step("rp_next",     1, 0, 1, 0, ev(0, 0, 0, 1, 0, 1, 3'b100, 2'd0, 0));
    step("rp_round",    1, 0, 1, 1, ev(0, 0, 0, 0, 0, 1, 3'b100, 2'd0, 0));
    step("in_score1",   1, 0, 0, 0, ev(0, 0, 0, 0, 0, 1, 3'b001, 2'd1, 0));
    step("in_legal2",   1, 1, 0, 0, ev(0, 1, 1, 0, 1, 1, 3'b001, 2'd1, 0));
    step("pb_single",   1, 0, 0, 1, ev(0, 0, 0, 0, 1, 0, 3'b010, 2'd1, 0));
    step("rp_wrong",    1, 0, 0, 1, ev(0, 0, 0, 0, 1, 1, 3'b100, 2'd1, 0));
    step("done_lose0",  1, 0, 0, 0, ev(0, 0, 0, 1, 0, 0, 3'b111, 2'd1, 0));
    step("done_lose1",  1, 1, 1, 1, ev(0, 0, 0, 0, 1, 0, 3'b111, 2'd1, 0));
    step("reset_done",  0, 0, 0, 0, ev(1, 0, 0, 0, 0, 1, 3'b001, 2'd1, 0));

    // two full rounds reach MAX_LEN and win
    step("g2_legal",    1, 1, 0, 0, ev(0, 1, 1, 0, 1, 1, 3'b001, 2'd0, 0));
    step("g2_pb",       1, 0, 0, 1, ev(0, 0, 0, 0, 1, 0, 3'b010, 2'd0, 0));
    step("g2_rp",       1, 0, 1, 1, ev(0, 0, 0, 0, 0, 1, 3'b100, 2'd0, 0));
    step("g2_legal2",   1, 1, 0, 0, ev(0, 1, 1, 0, 1, 1, 3'b001, 2'd1, 0));
    step("g2_pb_a",     1, 0, 0, 0, ev(0, 0, 0, 1, 0, 0, 3'b010, 2'd1, 0));
    step("g2_pb_b",     1, 0, 0, 1, ev(0, 0, 0, 0, 1, 0, 3'b010, 2'd1, 0));
    step("g2_rp_a",     1, 0, 1, 0, ev(0, 0, 0, 1, 0, 1, 3'b100, 2'd1, 0));
    step("g2_rp_win",   1, 0, 1, 1, ev(0, 0, 0, 0, 1, 1, 3'b100, 2'd1, 0));
    step("win_loop0",   1, 0, 0, 0, ev(0, 0, 0, 1, 0, 0, 3'b111, 2'd2, 1));
    step("win_loop1",   1, 0, 1, 1, ev(0, 0, 0, 0, 1, 0, 3'b111, 2'd2, 1));
    step("win_loop2",   1, 1, 0, 0, ev(0, 0, 0, 1, 0, 0, 3'b111, 2'd2, 1));
    step("reset_win",   0, 0, 0, 1, ev(1, 0, 0, 0, 0, 1, 3'b001, 2'd2, 1));

    // reset asserted mid-REPEAT suppresses the pending rcld
    step("g3_legal",    1, 1, 0, 0, ev(0, 1, 1, 0, 1, 1, 3'b001, 2'd0, 0));
    step("g3_pb",       1, 0, 0, 1, ev(0, 0, 0, 0, 1, 0, 3'b010, 2'd0, 0));
    step("reset_rp",    0, 0, 1, 0, ev(1, 0, 0, 0, 0, 1, 3'b001, 2'd0, 0));
    step("after_rst",   1, 0, 1, 0, ev(0, 0, 0, 0, 0, 1, 3'b001, 2'd0, 0));

    // INPUT ignores the replay status flags while no legal entry is present
    for (int i = 0; i < 6; i++) begin
      step("in_rand", 1, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ev(0, 0, 0, 0, 0, 1, 3'b001, 2'd0, 0));
    end

    check("queue_empty", VW'(exp_q.size()), VW'(0));
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
